// File: rtl/mul_div_unit_div_pkg.sv
// Shared state encoding and word constants for the iterative divider.
package mul_div_unit_div_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

    localparam int DATA_BUS = 32;
    localparam logic [DATA_BUS-1:0]   ZERO_WORD     = '0;
    localparam logic [2*DATA_BUS-1:0] ZERO_DBL_WORD = '0;

endpackage

// File: rtl/mul_div_unit_div.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle, WIDTH cycles,
// result {remainder, quotient} presented on a registered one-cycle ready pulse.
module mul_div_unit_div
    import mul_div_unit_div_pkg::*;
#(
    parameter int WIDTH = DATA_BUS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     opr1,
    input  logic [WIDTH-1:0]     opr2,
    input  logic                 flush,
    output logic [2*WIDTH-1:0]   res,
    output logic                 ready
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    div_state_e          state;
    div_state_e          state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [WIDTH-1:0]    dvd;
    logic [WIDTH-1:0]    dvs;
    logic [WIDTH-1:0]    rem;
    logic                quo_neg;
    logic                rem_neg;

    logic                accept;
    logic                div_zero;
    logic                last_iter;
    logic [WIDTH:0]      rem_sh;
    logic [WIDTH:0]      diff;
    logic [WIDTH-1:0]    rem_nxt;
    logic [WIDTH-1:0]    dvd_nxt;
    logic                ready_nxt;
    logic [2*WIDTH-1:0]  res_nxt;

    assign accept    = (state == DIV_IDLE) && start && !flush;
    assign div_zero  = (opr2 == '0);
    assign last_iter = (state == DIV_BUSY) && (cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = DIV_IDLE;
        end else begin
            case (state)
                DIV_IDLE: if (start) state_nxt = div_zero ? DIV_DONE : DIV_BUSY;
                DIV_BUSY: if (cnt == LAST_CNT) state_nxt = DIV_DONE;
                DIV_DONE: state_nxt = DIV_IDLE;
                default:  state_nxt = DIV_IDLE;
            endcase
        end
    end

    // One restoring step: the shifted 33-bit partial remainder never exceeds 2*divisor,
    // so bit WIDTH of the trial difference is a reliable sign.
    always_comb begin
        rem_sh = {rem, dvd[WIDTH-1]};
        diff   = rem_sh - {1'b0, dvs};
        if (!diff[WIDTH]) begin
            rem_nxt = diff[WIDTH-1:0];
            dvd_nxt = {dvd[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt = rem_sh[WIDTH-1:0];
            dvd_nxt = {dvd[WIDTH-2:0], 1'b0};
        end
    end

    // Result is formed on the edge that enters DONE so ready/res leave as plain registers.
    always_comb begin
        ready_nxt = 1'b0;
        res_nxt   = res;
        if (accept && div_zero) begin
            ready_nxt = 1'b1;
            res_nxt   = {opr1, {WIDTH{1'b1}}};
        end else if (last_iter && !flush) begin
            ready_nxt = 1'b1;
            res_nxt   = {cond_neg(rem_nxt, rem_neg), cond_neg(dvd_nxt, quo_neg)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready   <= 1'b0;
            res     <= ZERO_DBL_WORD;
            cnt     <= '0;
            dvd     <= '0;
            dvs     <= '0;
            rem     <= '0;
            quo_neg <= 1'b0;
            rem_neg <= 1'b0;
        end else begin
            ready <= ready_nxt;
            res   <= res_nxt;
            if (accept) begin
                dvd     <= cond_neg(opr1, sgn & opr1[WIDTH-1]);
                dvs     <= cond_neg(opr2, sgn & opr2[WIDTH-1]);
                quo_neg <= sgn & (opr1[WIDTH-1] ^ opr2[WIDTH-1]);
                rem_neg <= sgn & opr1[WIDTH-1];
                rem     <= '0;
                cnt     <= '0;
            end else if (state == DIV_BUSY) begin
                rem <= rem_nxt;
                dvd <= dvd_nxt;
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit_div.sv
// Directed and randomized checks of mul_div_unit_div against a plain-arithmetic model.
module tb_mul_div_unit_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sgn;
    logic        flush;
    logic [31:0] opr1;
    logic [31:0] opr2;
    logic [63:0] res;
    logic        ready;

    int checks = 0;
    int errors = 0;

    mul_div_unit_div #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sgn   (sgn),
        .opr1  (opr1),
        .opr2  (opr2),
        .flush (flush),
        .res   (res),
        .ready (ready)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic check64(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called #1 after a rising edge with the DUT in IDLE; returns in the following IDLE cycle.
    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input bit hold, input string tag);
        int k;
        int lat;
        lat   = (b == 32'd0) ? 1 : 33;
        start = 1'b1;
        sgn   = s;
        opr1  = a;
        opr2  = b;
        k     = 0;
        do begin
            @(posedge clk); #1;
            k++;
            if (!hold) start = 1'b0;
        end while (!ready && k < 40);
        check_int({tag, "_ready"}, int'(ready), 1);
        check_int({tag, "_latency"}, k, lat);
        check64({tag, "_res"}, res, exp);
        start = 1'b0;
        @(posedge clk); #1;
        check_int({tag, "_pulse"}, int'(ready), 0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        int          seen;

        rst   = 1'b1;
        start = 1'b0;
        sgn   = 1'b0;
        flush = 1'b0;
        opr1  = '0;
        opr2  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_int("reset_ready", int'(ready), 0);
        check64("reset_res", res, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b1, "u100_7");
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b1, "s-7_2");
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 1'b1, "s7_-2");
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 1'b1, "s_ovf");
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF}, 1'b1, "u_max_1");
        run_div(1'b1, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 1'b1, "s_dz");
        run_div(1'b0, 32'hFFFF_FFF0, 32'd0, {32'hFFFF_FFF0, 32'hFFFF_FFFF}, 1'b1, "u_dz");
        run_div(1'b0, 32'd1000, 32'd9, {32'd1, 32'd111}, 1'b0, "start_drop");

        // Flush in cycle T+10 aborts; a new divide accepted at T+11.
        start = 1'b1;
        sgn   = 1'b0;
        opr1  = 32'd1000;
        opr2  = 32'd3;
        seen  = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (ready) seen++;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        if (ready) seen++;
        flush = 1'b0;
        check_int("flush_no_ready", seen, 0);
        run_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b1, "after_flush");

        // Reset mid-divide clears outputs on the next edge.
        start = 1'b1;
        sgn   = 1'b1;
        opr1  = 32'hFFFF_FF00;
        opr2  = 32'd7;
        repeat (6) @(posedge clk);
        #1;
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        check_int("rst_ready", int'(ready), 0);
        check64("rst_res", res, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        run_div(1'b0, 32'd123456, 32'd321, model(1'b0, 32'd123456, 32'd321), 1'b1, "b2b_a");
        run_div(1'b1, 32'hFFFE_1DC0, 32'd1000, model(1'b1, 32'hFFFE_1DC0, 32'd1000), 1'b1, "b2b_b");

        for (int n = 0; n < 24; n++) begin
            rs = 1'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 20);
                2:       rb = 32'hFFFF_FFFF - $urandom_range(0, 20);
                default: rb = $urandom;
            endcase
            run_div(rs, ra, rb, model(rs, ra, rb), 1'b1, $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_div_unit_div.md
# mul_div_unit_div

Iterative radix-2 restoring divider serving the EX stage's `DIV`/`DIVU` instructions. EX holds `start` high with operands while stalling the pipeline. This block runs 32 shift/subtract iterations, then pulses `ready` with `{remainder, quotient}` on `res`, which EX writes to HI/LO. It is a self-contained sequential unit, instantiated beside EX in the top level.

## Interface
- `WIDTH`, 32, operand width; iteration count equals `WIDTH`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  divide request; EX holds it high (with stable operands) until `ready`.
- `sgn`  in  1  1 = signed (`DIV`), 0 = unsigned (`DIVU`); sampled with `start`.
- `opr1`  in  WIDTH  dividend; sampled with `start`.
- `opr2`  in  WIDTH  divisor; sampled with `start`.
- `flush`  in  1  pipeline flush (exception/eret); aborts any operation.
- `res`  out  2*WIDTH  `{remainder, quotient}`; `res[63:32]` → HI, `res[31:0]` → LO.
- `ready`  out  1  one-cycle pulse; `res` is valid in that cycle.

## Operation
States: `IDLE`, `BUSY`, `DONE`.

- **`IDLE`**: if `start && !flush`:
  - Latch `|opr1|` and `|opr2|` (absolute values only when `sgn`; else raw).
  - Latch quotient sign = `sgn & (opr1[31]^opr2[31])`.
  - Latch remainder sign = `sgn & opr1[31]`.
  - Clear the 33-bit partial remainder and the iteration counter.
  - If `opr2 == 0`, go to `DONE`; else go to `BUSY`.
- **`BUSY`**: each cycle:
  - Shift `{rem, dividend}` left by 1.
  - Trial-subtract the divisor from the upper 33 bits.
  - If the result is non-negative, keep it and set quotient bit 1; else restore and set 0.
  - Increment the counter. After iteration `WIDTH` (counter = 31 at the edge), go to `DONE`.
- **`DONE`**:
  - `ready` = 1.
  - `res` = sign-corrected `{rem, quo}`: two's-complement negate `quo` if the quotient sign is set, negate `rem` if the remainder sign is set.
  - Next state is always `IDLE`.
- **Divide by zero** (architecturally unpredictable; decided here): `res = {opr1, 32'hFFFFFFFF}` for both signed and unsigned, no sign correction, `ready` in the cycle after acceptance.
- **Signed overflow**: `0x80000000 / 0xFFFFFFFF` gives `quo = 0x80000000`, `rem = 0`. This falls out of unsigned-magnitude arithmetic; no special case.
- **`flush`**: in any state, the next state is `IDLE`, `ready` = 0, and the partial result is discarded. `flush` has priority over `start` and over `DONE`.
- **`start` deasserted during `BUSY`** (no flush): ignored. The operation completes and `ready` still pulses.
- **Restart after `DONE`**: if EX still holds the instruction after `DONE` (external stall), `start` rises again and a full recomputation occurs with an identical result. This is accepted behaviour.
- `res` holds its last value outside `DONE`; consumers use it only with `ready`.

## Timing
- Reset: state `IDLE`, `ready` = 0, `res` = 0, counter = 0, internal operand registers = 0.
- `start` first high in cycle T (`IDLE`) → `BUSY` in T+1..T+32 → `DONE` in T+33: `ready` = 1 and `res` valid. Back in `IDLE` at T+34, where a new `start` is accepted.
- Divide by zero: `start` in T → `ready` in T+1.
- `ready` and `res` are registered outputs with no combinational path from inputs. EX's `start = !ready` is therefore loop-free.
- `rst` mid-operation: same as `flush`, and outputs return to their reset values on the next edge.
- Operands are not re-sampled during `BUSY`.

## Structure
- Shared defines (existing `defines.v`):
  - State encodings `DIV_IDLE`, `DIV_BUSY`, `DIV_DONE` (2 bits).
  - Reuse `ZeroWord`, `ZeroDblWord`, `DataBus`, `DblData`, `true`, `false`.
- Single module; no sub-module is natural:
  - Absolute value and negation are inline expressions.
  - Trial subtract is one 33-bit subtractor.
- The top level wires EX's `div_start`, `div_signed`, `div_opr1`, `div_opr2` to `start`, `sgn`, `opr1`, `opr2`, and `div_res`/`div_ready` from `res`/`ready`. `flush` comes from the control/exception flush signal.

## Test plan
- Unsigned 100 / 7, `start` held until `ready` → `ready` exactly 33 cycles after first `start` cycle, `res = {32'd2, 32'd14}`, single-cycle pulse.
- Signed -7 / 2 → `res = {32'hFFFFFFFF, 32'hFFFFFFFD}`. Signed 7 / -2 → `{32'd1, 32'hFFFFFFFD}`.
- Signed `0x80000000 / 0xFFFFFFFF` → `res = {32'h0, 32'h80000000}`. Unsigned `0xFFFFFFFF / 1` → `{32'h0, 32'hFFFFFFFF}`.
- Divide by zero, 5 / 0 signed → `ready` the cycle after `start`, `res = {32'd5, 32'hFFFFFFFF}`.
- `flush` in cycle T+10 of a divide → `ready` never pulses for it. `start` with 9 / 3 at T+11 → `res = {0, 3}` at T+44.
- `rst` asserted during `BUSY` → `ready` = 0 and `res` = 0 next cycle. After release, a back-to-back pair of divides (second `start` at the `IDLE` cycle after `DONE`) both produce correct results.
